// File: rtl/packet_grant_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : packet_grant_scheduler_if
// Description : Request/grant bundle between the per-port ingress FIFOs, the
//               packet grant scheduler and the write data mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface packet_grant_scheduler_if #(
    parameter int NUM_OF_PORTS   = 16,
    parameter int PRIORITY_WIDTH = 3,
    parameter int SELECT_WIDTH   = 4
);
    logic                                   sp0_wrr1;
    logic [NUM_OF_PORTS-1:0]                ready;
    logic [NUM_OF_PORTS-1:0]                vld;
    logic [NUM_OF_PORTS-1:0]                eop;
    logic [NUM_OF_PORTS*PRIORITY_WIDTH-1:0] priority_in;
    logic [NUM_OF_PORTS-1:0]                grant;
    logic [SELECT_WIDTH-1:0]                select;
    logic                                   transfering;
    logic                                   busy;

    // Ingress side: drives requests and packet beats, observes the grant.
    modport master (
        output sp0_wrr1, ready, vld, eop, priority_in,
        input  grant, select, transfering, busy
    );

    // Scheduler side.
    modport slave (
        input  sp0_wrr1, ready, vld, eop, priority_in,
        output grant, select, transfering, busy
    );
endinterface
`default_nettype wire

// File: rtl/packet_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : packet_grant_scheduler
// Description : Packet-level grant scheduler for the SRAM write path. Picks
//               one requesting port by strict priority or weighted round
//               robin and holds the grant until that port's vld&eop.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_grant_scheduler #(
    parameter int NUM_OF_PORTS   = 16,
    parameter int PRIORITY_WIDTH = 3,
    parameter int SELECT_WIDTH   = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    packet_grant_scheduler_if.slave bus
);

    localparam int CRED_W = PRIORITY_WIDTH + 1;
    localparam int SUM_W  = SELECT_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t                  r_state_q;
    logic [NUM_OF_PORTS-1:0] r_grant_q;
    logic [SELECT_WIDTH-1:0] r_select_q;
    logic                    r_xfer_q;
    logic                    r_busy_q;
    logic                    r_mode_q;      // policy in force for the packet in flight
    logic [SELECT_WIDTH-1:0] r_rr_ptr_q;
    logic [CRED_W-1:0]       r_credit_q [NUM_OF_PORTS];

    logic [PRIORITY_WIDTH-1:0] w_prio       [NUM_OF_PORTS];
    logic [CRED_W-1:0]         w_reload     [NUM_OF_PORTS];
    logic [CRED_W-1:0]         w_eff_credit [NUM_OF_PORTS];

    logic                      w_any_ready;
    logic                      w_pkt_end;
    logic                      w_sp_found;
    logic [SELECT_WIDTH-1:0]   w_sp_idx;
    logic [PRIORITY_WIDTH-1:0] w_sp_best;
    logic                      w_need_reload;
    logic                      w_wrr_found;
    logic [SELECT_WIDTH-1:0]   w_wrr_idx;
    logic [SUM_W-1:0]          w_scan_sum;
    logic [SELECT_WIDTH-1:0]   w_scan_idx;
    logic [SELECT_WIDTH-1:0]   w_win_idx;
    logic [NUM_OF_PORTS-1:0]   w_win_onehot;
    logic [SELECT_WIDTH-1:0]   w_ptr_next;

    // Per-port priority field and the credit it reloads to (field + 1).
    for (genvar gi = 0; gi < NUM_OF_PORTS; gi++) begin : g_port
        assign w_prio[gi]   = bus.priority_in[gi*PRIORITY_WIDTH +: PRIORITY_WIDTH];
        assign w_reload[gi] = {1'b0, w_prio[gi]} + CRED_W'(1);
    end

    assign w_any_ready  = |bus.ready;
    assign w_pkt_end    = bus.vld[r_select_q] & bus.eop[r_select_q];
    assign w_win_idx    = bus.sp0_wrr1 ? w_wrr_idx : w_sp_idx;
    assign w_win_onehot = {{(NUM_OF_PORTS-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_ptr_next   = (r_select_q == SELECT_WIDTH'(NUM_OF_PORTS-1))
                          ? '0 : r_select_q + SELECT_WIDTH'(1);

    // Strict priority: highest field wins, strict '>' keeps the lowest index on ties.
    always_comb begin
        w_sp_found = 1'b0;
        w_sp_idx   = '0;
        w_sp_best  = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (bus.ready[i] && (!w_sp_found || (w_prio[i] > w_sp_best))) begin
                w_sp_found = 1'b1;
                w_sp_idx   = SELECT_WIDTH'(i);
                w_sp_best  = w_prio[i];
            end
        end
    end

    // WRR: reload in place when no requester has credit, then scan from rr_ptr.
    always_comb begin
        w_need_reload = 1'b1;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (bus.ready[i] && (r_credit_q[i] != '0)) begin
                w_need_reload = 1'b0;
            end
        end
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            w_eff_credit[i] = w_need_reload ? w_reload[i] : r_credit_q[i];
        end
        w_wrr_found = 1'b0;
        w_wrr_idx   = '0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NUM_OF_PORTS; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr_q} + SUM_W'(k);
            if (w_scan_sum >= SUM_W'(NUM_OF_PORTS)) begin
                w_scan_sum = w_scan_sum - SUM_W'(NUM_OF_PORTS);
            end
            w_scan_idx = w_scan_sum[SELECT_WIDTH-1:0];
            if (!w_wrr_found && bus.ready[w_scan_idx] && (w_eff_credit[w_scan_idx] != '0)) begin
                w_wrr_found = 1'b1;
                w_wrr_idx   = w_scan_idx;
            end
        end
    end

    // Control FSM with registered grant/select/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_grant_q  <= '0;
            r_select_q <= '0;
            r_xfer_q   <= 1'b0;
            r_busy_q   <= 1'b0;
            r_mode_q   <= 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_any_ready) begin
                        r_state_q <= ST_ARB;
                        r_busy_q  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (w_any_ready) begin
                        r_state_q  <= ST_XFER;
                        r_grant_q  <= w_win_onehot;
                        r_select_q <= w_win_idx;
                        r_xfer_q   <= 1'b1;
                        r_mode_q   <= bus.sp0_wrr1;
                    end else begin
                        r_state_q <= ST_IDLE;
                        r_busy_q  <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (w_pkt_end) begin
                        r_state_q <= ST_IDLE;
                        r_grant_q <= '0;
                        r_xfer_q  <= 1'b0;
                        r_busy_q  <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                    r_grant_q <= '0;
                    r_xfer_q  <= 1'b0;
                    r_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // WRR bookkeeping: reload on starved arbitration, spend one credit per packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                r_credit_q[i] <= '0;
            end
            r_rr_ptr_q <= '0;
        end else if ((r_state_q == ST_ARB) && bus.sp0_wrr1 && w_any_ready && w_need_reload) begin
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                r_credit_q[i] <= w_reload[i];
            end
        end else if ((r_state_q == ST_XFER) && w_pkt_end && r_mode_q) begin
            if (r_credit_q[r_select_q] != '0) begin
                r_credit_q[r_select_q] <= r_credit_q[r_select_q] - CRED_W'(1);
            end
            // Last credit spent: precedence moves to the next port.
            if (r_credit_q[r_select_q] == CRED_W'(1)) begin
                r_rr_ptr_q <= w_ptr_next;
            end
        end
    end

    assign bus.grant       = r_grant_q;
    assign bus.select      = r_select_q;
    assign bus.transfering = r_xfer_q;
    assign bus.busy        = r_busy_q;

endmodule
`default_nettype wire
